// File: rtl/plab4_net_router_input_queue_tp_if.sv
`default_nettype none
// ============================================================================
// Module : plab4_net_router_input_queue_tp_if
// Brief  : Bundle of every handshake and data signal of the timing-protected
//          router input queue, for both security domains.
//          master : producer/consumer side (upstream link + downstream arbiter)
//          slave  : the queue itself
// Ports  : in_val/in_rdy/in_msg          enqueue handshake per domain
//          out_val/out_rdy/out_msg       dequeue handshake per domain
//          out_dest/out_cnt              head destination and occupancy
// Rev    : 1.0  initial release
// ============================================================================
interface plab4_net_router_input_queue_tp_if #(
  parameter int p_msg_nbits   = 44,
  parameter int p_num_entries = 4,
  parameter int p_num_routers = 8
);
  localparam int c_dest_nbits = $clog2(p_num_routers);
  localparam int c_cnt_nbits  = $clog2(p_num_entries) + 1;

  // domain 0
  logic                    in_val_d0;
  logic                    in_rdy_d0;
  logic [p_msg_nbits-1:0]  in_msg_d0;
  logic                    out_val_d0;
  logic                    out_rdy_d0;
  logic [p_msg_nbits-1:0]  out_msg_d0;
  logic [c_dest_nbits-1:0] out_dest_d0;
  logic [c_cnt_nbits-1:0]  out_cnt_d0;

  // domain 1
  logic                    in_val_d1;
  logic                    in_rdy_d1;
  logic [p_msg_nbits-1:0]  in_msg_d1;
  logic                    out_val_d1;
  logic                    out_rdy_d1;
  logic [p_msg_nbits-1:0]  out_msg_d1;
  logic [c_dest_nbits-1:0] out_dest_d1;
  logic [c_cnt_nbits-1:0]  out_cnt_d1;

  modport master (
    output in_val_d0, in_msg_d0, out_rdy_d0,
    output in_val_d1, in_msg_d1, out_rdy_d1,
    input  in_rdy_d0, out_val_d0, out_msg_d0, out_dest_d0, out_cnt_d0,
    input  in_rdy_d1, out_val_d1, out_msg_d1, out_dest_d1, out_cnt_d1
  );

  modport slave (
    input  in_val_d0, in_msg_d0, out_rdy_d0,
    input  in_val_d1, in_msg_d1, out_rdy_d1,
    output in_rdy_d0, out_val_d0, out_msg_d0, out_dest_d0, out_cnt_d0,
    output in_rdy_d1, out_val_d1, out_msg_d1, out_dest_d1, out_cnt_d1
  );
endinterface
`default_nettype wire

// File: rtl/plab4_net_router_input_queue_tp.sv
`default_nettype none
// ============================================================================
// Module : plab4_net_router_input_queue_tp
// Brief  : Router input-port buffering with timing-channel protection. Two
//          statically partitioned FIFOs, one per security domain, with no
//          shared storage, pointer or status so neither domain can observe
//          the other through timing.
// Ports  : clk    clock, all state updates on posedge
//          reset  asynchronous active-high reset
//          q_if   slave side of plab4_net_router_input_queue_tp_if
//                 (enqueue/dequeue handshakes, head dest, occupancy per domain)
// Rev    : 1.0  initial release
// ============================================================================
module plab4_net_router_input_queue_tp #(
  parameter int p_msg_nbits   = 44,
  parameter int p_num_entries = 4,
  parameter int p_num_routers = 8
) (
  input  logic                                    clk,
  input  logic                                    reset,
  plab4_net_router_input_queue_tp_if.slave        q_if
);
  localparam int c_dest_nbits = $clog2(p_num_routers);
  localparam int c_cnt_nbits  = $clog2(p_num_entries) + 1;
  localparam int c_ptr_nbits  = $clog2(p_num_entries);
  localparam logic [c_cnt_nbits-1:0] c_full = c_cnt_nbits'(p_num_entries);

  // Per-domain views of the interface, indexed by domain so both FIFOs
  // come from one generate body.
  logic                   w_in_val  [2];
  logic [p_msg_nbits-1:0] w_in_msg  [2];
  logic                   w_out_rdy [2];
  logic                   w_in_rdy  [2];
  logic                   w_out_val [2];
  logic [p_msg_nbits-1:0] w_out_msg [2];
  logic [c_cnt_nbits-1:0] w_out_cnt [2];

  assign w_in_val[0]  = q_if.in_val_d0;
  assign w_in_msg[0]  = q_if.in_msg_d0;
  assign w_out_rdy[0] = q_if.out_rdy_d0;
  assign w_in_val[1]  = q_if.in_val_d1;
  assign w_in_msg[1]  = q_if.in_msg_d1;
  assign w_out_rdy[1] = q_if.out_rdy_d1;

  assign q_if.in_rdy_d0   = w_in_rdy[0];
  assign q_if.out_val_d0  = w_out_val[0];
  assign q_if.out_msg_d0  = w_out_msg[0];
  assign q_if.out_dest_d0 = w_out_msg[0][p_msg_nbits-1 -: c_dest_nbits];
  assign q_if.out_cnt_d0  = w_out_cnt[0];
  assign q_if.in_rdy_d1   = w_in_rdy[1];
  assign q_if.out_val_d1  = w_out_val[1];
  assign q_if.out_msg_d1  = w_out_msg[1];
  assign q_if.out_dest_d1 = w_out_msg[1][p_msg_nbits-1 -: c_dest_nbits];
  assign q_if.out_cnt_d1  = w_out_cnt[1];

  for (genvar g = 0; g < 2; g++) begin : g_dom
    logic [c_ptr_nbits-1:0] enq_ptr_q, enq_ptr_d;
    logic [c_ptr_nbits-1:0] deq_ptr_q, deq_ptr_d;
    logic [c_cnt_nbits-1:0] count_q,   count_d;
    logic [p_msg_nbits-1:0] storage_q [p_num_entries];
    logic                   w_enq;
    logic                   w_deq;

    // Ready/valid depend only on registered count: a full queue refuses
    // a new message even if the head leaves in the same cycle.
    assign w_in_rdy[g]  = (count_q != c_full);
    assign w_out_val[g] = (count_q != '0);
    assign w_enq        = w_in_val[g]  && w_in_rdy[g];
    assign w_deq        = w_out_rdy[g] && w_out_val[g];
    assign w_out_msg[g] = storage_q[deq_ptr_q];
    assign w_out_cnt[g] = count_q;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
      enq_ptr_d = enq_ptr_q;
      deq_ptr_d = deq_ptr_q;
      count_d   = count_q;
      if (w_enq) enq_ptr_d = enq_ptr_q + c_ptr_nbits'(1);
      if (w_deq) deq_ptr_d = deq_ptr_q + c_ptr_nbits'(1);
      case ({w_enq, w_deq})
        2'b10:   count_d = count_q + c_cnt_nbits'(1);
        2'b01:   count_d = count_q - c_cnt_nbits'(1);
        default: count_d = count_q;
      endcase
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        enq_ptr_q <= '0;
        deq_ptr_q <= '0;
        count_q   <= '0;
      end else begin
        enq_ptr_q <= enq_ptr_d;
        deq_ptr_q <= deq_ptr_d;
        count_q   <= count_d;
      end
    end

    // Message storage carries no reset; contents are only observed while
    // count marks them valid.
    always_ff @(posedge clk) begin
      if (w_enq) storage_q[enq_ptr_q] <= w_in_msg[g];
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_plab4_net_router_input_queue_tp.sv
`default_nettype none
// ============================================================================
// Module : tb_plab4_net_router_input_queue_tp
// Brief  : Directed self-checking bench for the timing-protected input queue.
// Rev    : 1.0  initial release
// ============================================================================
module tb_plab4_net_router_input_queue_tp;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  plab4_net_router_input_queue_tp_if #(
    .p_msg_nbits(44), .p_num_entries(4), .p_num_routers(8)
  ) q_if ();

  plab4_net_router_input_queue_tp #(
    .p_msg_nbits(44), .p_num_entries(4), .p_num_routers(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .q_if  (q_if)
  );

  always #5 clk = ~clk;

  // Reference trace of the d0 stream run on its own.
  logic        ref_val [14];
  logic [43:0] ref_msg [14];
  logic [2:0]  ref_cnt [14];
  logic        ref_rdy [14];

  function automatic logic [43:0] mk(input int dest, input int id);
    logic [2:0]  d;
    logic [40:0] p;
    d = 3'(dest);
    p = 41'(32'h0000_A500 + id);
    return {d, p};
  endfunction

  task automatic test_reset();
    // Put state in both queues, then assert reset between edges.
    q_if.in_val_d0 = 1; q_if.in_msg_d0 = mk(1, 1);
    q_if.in_val_d1 = 1; q_if.in_msg_d1 = mk(2, 2);
    @(negedge clk);
    @(negedge clk);
    q_if.in_val_d0 = 0; q_if.in_val_d1 = 0;
    n_checks++;
    if (q_if.out_cnt_d0 !== 3'd2) $display("FAIL pre_reset_cnt_d0 got %0d exp 2", q_if.out_cnt_d0);
    else n_pass++;
    #2 reset = 1;
    #1;
    n_checks++;
    if (q_if.in_rdy_d0 !== 1'b1) $display("FAIL t1_in_rdy_d0 got %b exp 1", q_if.in_rdy_d0); else n_pass++;
    n_checks++;
    if (q_if.in_rdy_d1 !== 1'b1) $display("FAIL t1_in_rdy_d1 got %b exp 1", q_if.in_rdy_d1); else n_pass++;
    n_checks++;
    if (q_if.out_val_d0 !== 1'b0) $display("FAIL t1_out_val_d0 got %b exp 0", q_if.out_val_d0); else n_pass++;
    n_checks++;
    if (q_if.out_val_d1 !== 1'b0) $display("FAIL t1_out_val_d1 got %b exp 0", q_if.out_val_d1); else n_pass++;
    n_checks++;
    if (q_if.out_cnt_d0 !== 3'd0) $display("FAIL t1_cnt_d0 got %0d exp 0", q_if.out_cnt_d0); else n_pass++;
    n_checks++;
    if (q_if.out_cnt_d1 !== 3'd0) $display("FAIL t1_cnt_d1 got %0d exp 0", q_if.out_cnt_d1); else n_pass++;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_enq_one();
    q_if.in_val_d0 = 1; q_if.in_msg_d0 = mk(3, 10);
    n_checks++;
    if (q_if.out_val_d0 !== 1'b0) $display("FAIL t2_no_bypass got %b exp 0", q_if.out_val_d0); else n_pass++;
    @(negedge clk);
    q_if.in_val_d0 = 0;
    n_checks++;
    if (q_if.out_val_d0 !== 1'b1) $display("FAIL t2_out_val_d0 got %b exp 1", q_if.out_val_d0); else n_pass++;
    n_checks++;
    if (q_if.out_dest_d0 !== 3'd3) $display("FAIL t2_dest_d0 got %0d exp 3", q_if.out_dest_d0); else n_pass++;
    n_checks++;
    if (q_if.out_msg_d0 !== mk(3, 10)) $display("FAIL t2_msg_d0 got %h exp %h", q_if.out_msg_d0, mk(3, 10)); else n_pass++;
    n_checks++;
    if (q_if.out_cnt_d0 !== 3'd1) $display("FAIL t2_cnt_d0 got %0d exp 1", q_if.out_cnt_d0); else n_pass++;
    n_checks++;
    if (q_if.out_val_d1 !== 1'b0) $display("FAIL t2_out_val_d1 got %b exp 0", q_if.out_val_d1); else n_pass++;
    q_if.out_rdy_d0 = 1;
    @(negedge clk);
    q_if.out_rdy_d0 = 0;
    n_checks++;
    if (q_if.out_val_d0 !== 1'b0 || q_if.out_cnt_d0 !== 3'd0)
      $display("FAIL t2_drain got val=%b cnt=%0d exp val=0 cnt=0", q_if.out_val_d0, q_if.out_cnt_d0);
    else n_pass++;
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      q_if.in_val_d0 = 1; q_if.in_msg_d0 = mk(i + 1, 200 + i);
      @(negedge clk);
    end
    q_if.in_val_d0 = 0;
    n_checks++;
    if (q_if.in_rdy_d0 !== 1'b0) $display("FAIL t3_in_rdy_full got %b exp 0", q_if.in_rdy_d0); else n_pass++;
    n_checks++;
    if (q_if.out_cnt_d0 !== 3'd4) $display("FAIL t3_cnt_full got %0d exp 4", q_if.out_cnt_d0); else n_pass++;
    n_checks++;
    if (q_if.out_msg_d0 !== mk(1, 200)) $display("FAIL t3_head got %h exp %h", q_if.out_msg_d0, mk(1, 200)); else n_pass++;
    // Enqueue offered while full, dequeue in the same cycle: only deq fires.
    q_if.in_val_d0 = 1; q_if.in_msg_d0 = mk(7, 299); q_if.out_rdy_d0 = 1;
    @(negedge clk);
    q_if.in_val_d0 = 0; q_if.out_rdy_d0 = 0;
    n_checks++;
    if (q_if.out_cnt_d0 !== 3'd3) $display("FAIL t3_cnt_after got %0d exp 3", q_if.out_cnt_d0); else n_pass++;
    n_checks++;
    if (q_if.in_rdy_d0 !== 1'b1) $display("FAIL t3_in_rdy_after got %b exp 1", q_if.in_rdy_d0); else n_pass++;
    for (int i = 1; i < 4; i++) begin
      n_checks++;
      if (q_if.out_val_d0 !== 1'b1 || q_if.out_msg_d0 !== mk(i + 1, 200 + i))
        $display("FAIL t3_drain%0d got val=%b msg=%h exp val=1 msg=%h", i, q_if.out_val_d0, q_if.out_msg_d0, mk(i + 1, 200 + i));
      else n_pass++;
      q_if.out_rdy_d0 = 1;
      @(negedge clk);
    end
    q_if.out_rdy_d0 = 0;
    n_checks++;
    if (q_if.out_val_d0 !== 1'b0) $display("FAIL t3_refused_msg got val=%b exp 0", q_if.out_val_d0); else n_pass++;
  endtask

  // Ten messages streamed through d0 with the consumer always ready.
  // Step c samples after c edges: head is message c-1 for c in 1..10.
  task automatic run_stream(input bit compare_ref);
    logic        e_val;
    logic [2:0]  e_cnt;
    logic [43:0] e_msg;
    for (int c = 0; c < 14; c++) begin
      e_val = (c >= 1 && c <= 10);
      e_cnt = e_val ? 3'd1 : 3'd0;
      e_msg = mk((c - 1) % 8, 100 + c - 1);
      n_checks++;
      if (q_if.out_val_d0 !== e_val || q_if.out_cnt_d0 !== e_cnt || q_if.in_rdy_d0 !== 1'b1 ||
          (e_val && q_if.out_msg_d0 !== e_msg))
        $display("FAIL stream_step%0d got val=%b cnt=%0d rdy=%b msg=%h exp val=%b cnt=%0d rdy=1 msg=%h",
                 c, q_if.out_val_d0, q_if.out_cnt_d0, q_if.in_rdy_d0, q_if.out_msg_d0, e_val, e_cnt, e_msg);
      else n_pass++;
      if (compare_ref) begin
        n_checks++;
        if (q_if.out_val_d0 !== ref_val[c] || q_if.out_cnt_d0 !== ref_cnt[c] || q_if.in_rdy_d0 !== ref_rdy[c] ||
            (ref_val[c] && q_if.out_msg_d0 !== ref_msg[c]))
          $display("FAIL t5_trace_step%0d got val=%b cnt=%0d rdy=%b exp val=%b cnt=%0d rdy=%b",
                   c, q_if.out_val_d0, q_if.out_cnt_d0, q_if.in_rdy_d0, ref_val[c], ref_cnt[c], ref_rdy[c]);
        else n_pass++;
      end else begin
        ref_val[c] = q_if.out_val_d0;
        ref_msg[c] = q_if.out_msg_d0;
        ref_cnt[c] = q_if.out_cnt_d0;
        ref_rdy[c] = q_if.in_rdy_d0;
      end
      q_if.in_val_d0  = (c < 10);
      q_if.in_msg_d0  = mk(c % 8, 100 + c);
      q_if.out_rdy_d0 = 1;
      @(negedge clk);
    end
    q_if.in_val_d0 = 0; q_if.out_rdy_d0 = 0;
  endtask

  task automatic test_wrap();
    run_stream(1'b0);
  endtask

  task automatic test_isolation();
    for (int i = 0; i < 4; i++) begin
      q_if.in_val_d1 = 1; q_if.in_msg_d1 = mk(2, 300 + i);
      @(negedge clk);
    end
    // d1 stays full with a pending enqueue and a stalled consumer.
    q_if.in_msg_d1 = mk(6, 399);
    n_checks++;
    if (q_if.out_cnt_d1 !== 3'd4 || q_if.in_rdy_d1 !== 1'b0)
      $display("FAIL t5_d1_full got cnt=%0d rdy=%b exp cnt=4 rdy=0", q_if.out_cnt_d1, q_if.in_rdy_d1);
    else n_pass++;
    run_stream(1'b1);
    n_checks++;
    if (q_if.out_cnt_d1 !== 3'd4 || q_if.out_msg_d1 !== mk(2, 300))
      $display("FAIL t5_d1_held got cnt=%0d msg=%h exp cnt=4 msg=%h", q_if.out_cnt_d1, q_if.out_msg_d1, mk(2, 300));
    else n_pass++;
    q_if.in_val_d1 = 0;
  endtask

  task automatic test_reset_drop();
    q_if.out_rdy_d1 = 1;
    @(negedge clk);
    q_if.out_rdy_d1 = 0;
    n_checks++;
    if (q_if.out_cnt_d1 !== 3'd3 || q_if.out_msg_d1 !== mk(2, 301))
      $display("FAIL t6_three_queued got cnt=%0d msg=%h exp cnt=3 msg=%h", q_if.out_cnt_d1, q_if.out_msg_d1, mk(2, 301));
    else n_pass++;
    #2 reset = 1;
    #1;
    n_checks++;
    if (q_if.out_val_d1 !== 1'b0 || q_if.out_cnt_d1 !== 3'd0 || q_if.in_rdy_d1 !== 1'b1)
      $display("FAIL t6_reset got val=%b cnt=%0d rdy=%b exp val=0 cnt=0 rdy=1", q_if.out_val_d1, q_if.out_cnt_d1, q_if.in_rdy_d1);
    else n_pass++;
    @(negedge clk);
    reset = 0;
    q_if.in_val_d1 = 1; q_if.in_msg_d1 = mk(5, 400);
    @(negedge clk);
    q_if.in_val_d1 = 0;
    n_checks++;
    if (q_if.out_val_d1 !== 1'b1 || q_if.out_msg_d1 !== mk(5, 400) || q_if.out_dest_d1 !== 3'd5 || q_if.out_cnt_d1 !== 3'd1)
      $display("FAIL t6_new_msg got val=%b msg=%h dest=%0d cnt=%0d exp val=1 msg=%h dest=5 cnt=1",
               q_if.out_val_d1, q_if.out_msg_d1, q_if.out_dest_d1, q_if.out_cnt_d1, mk(5, 400));
    else n_pass++;
    q_if.out_rdy_d1 = 1;
    @(negedge clk);
    q_if.out_rdy_d1 = 0;
    n_checks++;
    if (q_if.out_val_d1 !== 1'b0 || q_if.out_cnt_d1 !== 3'd0)
      $display("FAIL t6_alone got val=%b cnt=%0d exp val=0 cnt=0", q_if.out_val_d1, q_if.out_cnt_d1);
    else n_pass++;
  endtask

  initial begin
    clk = 0;
    reset = 1;
    n_checks = 0;
    n_pass = 0;
    q_if.in_val_d0 = 0; q_if.in_msg_d0 = '0; q_if.out_rdy_d0 = 0;
    q_if.in_val_d1 = 0; q_if.in_msg_d1 = '0; q_if.out_rdy_d1 = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    test_reset();
    test_enq_one();
    test_full();
    test_wrap();
    test_isolation();
    test_reset_drop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
